store_word_merge: RTL

- Store-side counterpart of the load byte/half extraction logic in the MEM stage.
- Accepts SB/SH/SW requests from the pipeline and writes them into a word-only data memory.
- SW writes the word directly. SB/SH do a read-modify-write: read the word, merge the byte or halfword into the correct lane (little-endian), write the word back.
- Stalls the pipeline through req_ready while a store is in flight.

---
 rtl/store_word_merge.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/store_word_merge.sv
// store_word_merge: store path of the MEM stage in front of a word-only data
// memory. SW is written straight through; SB/SH read the addressed word,
// replace one byte or halfword lane (little-endian) and write the word back.
// The pipeline is held off through req_ready while a store is in flight.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE, so at most one store is in flight. The
// request fields matter only in that accept cycle. Once accepted, a request
// cannot be withdrawn.
module store_word_merge (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  store_type,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic        done,
    output logic        store_err,
    output logic [2:0]  dbg_state
);

    localparam logic [1:0] STORE_SB = 2'd0;
    localparam logic [1:0] STORE_SH = 2'd1;
    localparam logic [1:0] STORE_SW = 2'd2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        WRITE   = 3'd3,
        ERR     = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [1:0]  type_q;
    logic [31:0] merged_q;
    logic [31:0] merge_word;
    logic        accept;
    logic        req_bad;

    assign accept = req_valid && req_ready;

    // Illegal encoding or misaligned address for the requested width.
    always_comb begin
        req_bad = 1'b0;
        case (store_type)
            STORE_SB: req_bad = 1'b0;
            STORE_SH: req_bad = addr[0];
            STORE_SW: req_bad = (addr[1:0] != 2'b00);
            default:  req_bad = 1'b1;
        endcase
    end

    // Replace the addressed lane of the word read back; other bits pass through.
    always_comb begin
        merge_word = mem_rdata;
        if (type_q == STORE_SB) begin
            case (addr_q[1:0])
                2'd0:    merge_word[7:0]   = data_q[7:0];
                2'd1:    merge_word[15:8]  = data_q[7:0];
                2'd2:    merge_word[23:16] = data_q[7:0];
                default: merge_word[31:24] = data_q[7:0];
            endcase
        end else if (type_q == STORE_SH) begin
            if (addr_q[1]) begin
                merge_word[31:16] = data_q[15:0];
            end else begin
                merge_word[15:0] = data_q[15:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request capture on accept and merged word capture in CAPTURE.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= 32'h0;
            data_q   <= 32'h0;
            type_q   <= 2'd0;
            merged_q <= 32'h0;
        end else begin
            if (accept) begin
                addr_q <= addr;
                data_q <= store_data;
                type_q <= store_type;
            end
            if (state == CAPTURE) begin
                merged_q <= merge_word;
            end
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        done       = 1'b0;
        store_err  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_bad) begin
                        state_next = ERR;
                    end else if (store_type == STORE_SW) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ: begin
                mem_re     = 1'b1;
                state_next = CAPTURE;
            end
            CAPTURE: begin
                state_next = WRITE;
            end
            WRITE: begin
                mem_we     = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            ERR: begin
                store_err  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Address and write data come only from registers, so they are stable.
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = (type_q == STORE_SW) ? data_q : merged_q;
    assign dbg_state = state;

endmodule
